// File: rtl/dff_pipeline_pkg.sv
// Shared definitions for the dff_pipeline register pipeline.
// Instantiating blocks use clog2_count() to size their own occupancy buses.
package dff_pipeline_pkg;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int clog2_count(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipeline_pipe_stage.sv
// One pipeline stage: a valid flag and a data word with load-enable and clear.
// Data changes only on load, so a stalled stage holds its word bit-exact.
module pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ld,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v <= 1'b0;
            d <= RESET_VAL;
        end else begin
            if (ld) begin
                d <= din;
            end
            if (clr) begin
                v <= 1'b0;
            end else if (ld) begin
                v <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dff_pipeline.sv
// Backpressure-aware register pipeline: DEPTH stages with bubble collapsing,
// synchronous flush and a registered occupancy count.
module dff_pipeline
    import dff_pipeline_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [clog2_count(DEPTH)-1:0] count
);

    localparam int CW = clog2_count(DEPTH);

    logic [DEPTH-1:0] w_v;
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_ld;
    logic [DEPTH-1:0] w_clr;
    logic [WIDTH-1:0] w_d [DEPTH];
    logic             w_accept;
    logic             w_drain;
    logic [CW-1:0]    r_count;

    // The output port acts as a virtual always-full stage whose advance is out_ready,
    // so every stage uses the same advance equation.
    always_comb begin : adv_chain
        logic v_up;
        logic adv_up;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_adv  = '0;
        v_up   = 1'b1;
        adv_up = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_adv[i] = w_v[i] & (~v_up | adv_up);
            v_up     = w_v[i];
            adv_up   = w_adv[i];
        end
    end

    assign in_ready = reset_n & ~flush & (~w_v[0] | w_adv[0]);
    assign w_accept = in_valid & in_ready;
    assign w_drain  = w_v[DEPTH-1] & out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] w_din;

        if (i == 0) begin : g_head
            assign w_ld[i] = w_accept;
            assign w_din   = in_data;
        end else begin : g_body
            assign w_ld[i] = w_adv[i-1];
            assign w_din   = w_d[i-1];
        end

        assign w_clr[i] = flush | (w_adv[i] & ~w_ld[i]);

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .ld      (w_ld[i]),
            .clr     (w_clr[i]),
            .din     (w_din),
            .v       (w_v[i]),
            .d       (w_d[i])
        );
    end

    // Accept and drain in the same cycle cancel, so the count never leaves 0..DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            case ({w_accept, w_drain})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign count     = r_count;
    assign out_valid = w_v[DEPTH-1];
    assign out_data  = w_d[DEPTH-1];

endmodule
